// File: rtl/srec_load_pkg.sv
// srec_load_pkg
//   Shared types and constants for the S-record load sequencer.
//   - load_state_t : sequencer state encoding
//   - word_entry_t : one buffered word write {word address, data, byte enables}
//   - LANES        : byte lanes per memory word
//   - WORD_COUNT_W : width of the acknowledged-write counter
package srec_load_pkg;

    localparam int LANES        = 4;
    localparam int WORD_COUNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_HOLD,
        ST_DONE,
        ST_ERROR
    } load_state_t;

    // Word address excludes the two byte-offset bits, which are always zero
    // on the memory port.
    typedef struct packed {
        logic [29:0]      addr;
        logic [31:0]      data;
        logic [LANES-1:0] be;
    } word_entry_t;

endpackage

// File: rtl/srec_word_fifo.sv
// srec_word_fifo
//   Synchronous FIFO of word writes awaiting acknowledgement on the memory
//   port. Push and pop may occur in the same cycle, including when full.
//   Exposes both the head entry and the entry behind it so the drain logic
//   can present the following write on the cycle right after an ack.
//
// Ports
//   clock      in  : clock, rising edge
//   reset_n    in  : asynchronous active-low reset
//   clear      in  : discard all entries (takes priority over push/pop)
//   push       in  : write push_data (ignored when full without a pop)
//   push_data  in  : entry to store
//   pop        in  : remove head entry (ignored when empty)
//   head_data  out : entry at the head
//   next_data  out : entry behind the head
//   count      out : number of stored entries
//   full       out : count == DEPTH
//   empty      out : count == 0
module srec_word_fifo
    import srec_load_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  word_entry_t              push_data,
    input  logic                     pop,
    output word_entry_t              head_data,
    output word_entry_t              next_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    word_entry_t     mem_array [DEPTH];
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            push_ok;
    logic            pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // When full, the slot being written is the one being popped this cycle.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clock) begin
        if (push_ok && !clear) begin
            mem_array[wr_ptr_reg] <= push_data;
        end
    end

    assign head_data = mem_array[rd_ptr_reg];
    assign next_data = mem_array[rd_ptr_reg + AW'(1)];
    assign count     = count_reg;

endmodule

// File: rtl/srec_load_ctrl.sv
// srec_load_ctrl
//   Sequencer between the S-record parser and the memory write port. Packs
//   parser byte writes into word-aligned, byte-enabled 32-bit writes,
//   buffers them in srec_word_fifo, drains them over mem_req/mem_ack and
//   holds the CPU in reset while a load is in flight. The CPU is released
//   after the end of the load, the last ack and RESET_HOLD_CYCLES more.
//
//   Build option: SREC_LOAD_CTRL_BOOT_HOLD_EN
//     defined   - cpu_reset_n is low from reset through IDLE; the CPU only
//                 runs after a successful load.
//     undefined - cpu_reset_n is high in IDLE; the CPU boots from existing
//                 memory and is held only while a load is in flight.
//
// Ports
//   clock          in  : clock, rising edge
//   reset_n        in  : asynchronous active-low reset, clears all state
//   in_progress    in  : parser load-active level
//   format_error   in  : parser sticky format error
//   checksum_error in  : parser sticky checksum error
//   write_address  in  : parser byte address
//   write_byte     in  : parser byte
//   write_enable   in  : one-cycle byte strobe
//   mem_addr       out : word address, bits [1:0] zero
//   mem_wdata      out : byte at offset k on bits [8k+7:8k]
//   mem_be         out : lane k valid
//   mem_req        out : write request, held until mem_ack
//   mem_ack        in  : write accepted when high together with mem_req
//   cpu_reset_n    out : CPU reset, active-low
//   load_done      out : last load completed cleanly
//   load_error     out : sticky error, cleared only by reset_n
//   word_count     out : acknowledged writes in this load, saturating
module srec_load_ctrl
    import srec_load_pkg::*;
#(
    parameter int FIFO_DEPTH        = 4,
    parameter int RESET_HOLD_CYCLES = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_progress,
    input  logic                    format_error,
    input  logic                    checksum_error,
    input  logic [31:0]             write_address,
    input  logic [7:0]              write_byte,
    input  logic                    write_enable,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    output logic [3:0]              mem_be,
    output logic                    mem_req,
    input  logic                    mem_ack,
    output logic                    cpu_reset_n,
    output logic                    load_done,
    output logic                    load_error,
    output logic [WORD_COUNT_W-1:0] word_count
);

`ifdef SREC_LOAD_CTRL_BOOT_HOLD_EN
    localparam logic IDLE_CPU_RUN = 1'b0;
`else
    localparam logic IDLE_CPU_RUN = 1'b1;
`endif

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int HCW = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(RESET_HOLD_CYCLES - 1);

    load_state_t             state_reg;
    logic                    in_progress_prev_reg;
    logic [HCW-1:0]          hold_cnt_reg;

    // Partial-word pack buffer; empty when buf_be_reg == 0.
    logic [29:0]             buf_addr_reg;
    logic [31:0]             buf_data_reg;
    logic [LANES-1:0]        buf_be_reg;
    logic [29:0]             buf_addr_next;
    logic [31:0]             buf_data_next;
    logic [LANES-1:0]        buf_be_next;

    logic [29:0]             mem_addr_reg;
    logic [31:0]             mem_wdata_reg;
    logic [LANES-1:0]        mem_be_reg;
    logic                    mem_req_reg;
    logic                    cpu_reset_n_reg;
    logic                    load_done_reg;
    logic                    load_error_reg;
    logic [WORD_COUNT_W-1:0] word_count_reg;

    logic [29:0]             byte_word;
    logic [LANES-1:0]        hit_lane;
    logic [31:0]             merged_data;
    logic [31:0]             fresh_data;

    logic                    push_valid;
    word_entry_t             push_word;
    word_entry_t             fifo_head;
    word_entry_t             fifo_next;
    word_entry_t             drain_src;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    fifo_pop;

    logic                    ack_accept;
    logic                    overflow;
    logic                    active_state;
    logic                    go_error;
    logic                    rem_nonzero;
    logic                    in_rise;
    logic                    in_fall;
    logic                    flush_done;

    assign byte_word = write_address[31:2];

    // Per-lane byte steering: merged_data overlays the incoming byte on the
    // open buffer, fresh_data starts a new word holding only that byte.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign hit_lane[gi]          = (write_address[1:0] == 2'(gi));
            assign merged_data[8*gi +: 8] = hit_lane[gi] ? write_byte : buf_data_reg[8*gi +: 8];
            assign fresh_data[8*gi +: 8]  = hit_lane[gi] ? write_byte : 8'h00;
        end
    endgenerate

    // Packing: decides whether this cycle produces a word for the FIFO and
    // what the pack buffer holds afterwards.
    always_comb begin
        push_valid     = 1'b0;
        push_word      = '0;
        buf_addr_next  = buf_addr_reg;
        buf_data_next  = buf_data_reg;
        buf_be_next    = buf_be_reg;
        if (state_reg == ST_LOAD && write_enable) begin
            if (buf_be_reg == '0) begin
                buf_addr_next = byte_word;
                buf_data_next = fresh_data;
                buf_be_next   = hit_lane;
            end else if (byte_word == buf_addr_reg) begin
                if ((buf_be_reg | hit_lane) == 4'hF) begin
                    push_valid     = 1'b1;
                    push_word.addr = buf_addr_reg;
                    push_word.data = merged_data;
                    push_word.be   = 4'hF;
                    buf_data_next  = '0;
                    buf_be_next    = '0;
                end else begin
                    buf_data_next = merged_data;
                    buf_be_next   = buf_be_reg | hit_lane;
                end
            end else begin
                // Word change (address wrap included): flush old, reopen.
                push_valid     = 1'b1;
                push_word.addr = buf_addr_reg;
                push_word.data = buf_data_reg;
                push_word.be   = buf_be_reg;
                buf_addr_next  = byte_word;
                buf_data_next  = fresh_data;
                buf_be_next    = hit_lane;
            end
        end else if (state_reg == ST_FLUSH && buf_be_reg != '0) begin
            push_valid     = 1'b1;
            push_word.addr = buf_addr_reg;
            push_word.data = buf_data_reg;
            push_word.be   = buf_be_reg;
            buf_data_next  = '0;
            buf_be_next    = '0;
        end
    end

    assign ack_accept   = mem_req_reg && mem_ack;
    assign fifo_pop     = ack_accept && !fifo_empty;
    assign overflow     = push_valid && fifo_full && !fifo_pop;
    assign active_state = (state_reg == ST_LOAD) || (state_reg == ST_FLUSH) ||
                          (state_reg == ST_HOLD);
    assign go_error     = active_state && (format_error || checksum_error || overflow);
    assign fifo_push    = push_valid && !go_error;
    // FIFO still holds an unacknowledged entry after this cycle's pop.
    assign rem_nonzero  = !fifo_empty && !(fifo_pop && fifo_count == CW'(1));
    assign drain_src    = ack_accept ? fifo_next : fifo_head;
    assign in_rise      = in_progress && !in_progress_prev_reg;
    assign in_fall      = !in_progress && in_progress_prev_reg;
    assign flush_done   = (state_reg == ST_FLUSH) && (buf_be_reg == '0) && !rem_nonzero &&
                          !push_valid && (!mem_req_reg || ack_accept);

    srec_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (go_error),
        .push      (fifo_push),
        .push_data (push_word),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .next_data (fifo_next),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg            <= ST_IDLE;
            in_progress_prev_reg <= 1'b0;
            hold_cnt_reg         <= '0;
            buf_addr_reg         <= '0;
            buf_data_reg         <= '0;
            buf_be_reg           <= '0;
            mem_addr_reg         <= '0;
            mem_wdata_reg        <= '0;
            mem_be_reg           <= '0;
            mem_req_reg          <= 1'b0;
            cpu_reset_n_reg      <= IDLE_CPU_RUN;
            load_done_reg        <= 1'b0;
            load_error_reg       <= 1'b0;
            word_count_reg       <= '0;
        end else begin
            in_progress_prev_reg <= in_progress;

            if (go_error) begin
                buf_be_reg   <= '0;
                buf_data_reg <= '0;
            end else begin
                buf_addr_reg <= buf_addr_next;
                buf_data_reg <= buf_data_next;
                buf_be_reg   <= buf_be_next;
            end

            // Drain: an outstanding request always completes; after an
            // error nothing new is issued.
            if (go_error || state_reg == ST_ERROR) begin
                if (ack_accept) begin
                    mem_req_reg <= 1'b0;
                end
            end else if (!mem_req_reg || ack_accept) begin
                if (rem_nonzero) begin
                    mem_addr_reg  <= drain_src.addr;
                    mem_wdata_reg <= drain_src.data;
                    mem_be_reg    <= drain_src.be;
                    mem_req_reg   <= 1'b1;
                end else if (push_valid) begin
                    // Bypass so a word finished at cycle N is requested at N+1.
                    mem_addr_reg  <= push_word.addr;
                    mem_wdata_reg <= push_word.data;
                    mem_be_reg    <= push_word.be;
                    mem_req_reg   <= 1'b1;
                end else begin
                    mem_req_reg   <= 1'b0;
                end
            end

            if (ack_accept && word_count_reg != '1) begin
                word_count_reg <= word_count_reg + WORD_COUNT_W'(1);
            end

            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (in_rise) begin
                        state_reg       <= ST_LOAD;
                        word_count_reg  <= '0;
                        load_done_reg   <= 1'b0;
                        cpu_reset_n_reg <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (go_error) begin
                        state_reg       <= ST_ERROR;
                        load_error_reg  <= 1'b1;
                        cpu_reset_n_reg <= 1'b0;
                    end else if (in_fall) begin
                        state_reg <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (go_error) begin
                        state_reg       <= ST_ERROR;
                        load_error_reg  <= 1'b1;
                        cpu_reset_n_reg <= 1'b0;
                    end else if (flush_done) begin
                        state_reg    <= ST_HOLD;
                        hold_cnt_reg <= '0;
                    end
                end
                ST_HOLD: begin
                    if (go_error) begin
                        state_reg       <= ST_ERROR;
                        load_error_reg  <= 1'b1;
                        cpu_reset_n_reg <= 1'b0;
                    end else if (hold_cnt_reg == HOLD_LAST) begin
                        state_reg       <= ST_DONE;
                        cpu_reset_n_reg <= 1'b1;
                        load_done_reg   <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + HCW'(1);
                    end
                end
                ST_ERROR: begin
                    state_reg <= ST_ERROR;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr    = {mem_addr_reg, 2'b00};
    assign mem_wdata   = mem_wdata_reg;
    assign mem_be      = mem_be_reg;
    assign mem_req     = mem_req_reg;
    assign cpu_reset_n = cpu_reset_n_reg;
    assign load_done   = load_done_reg;
    assign load_error  = load_error_reg;
    assign word_count  = word_count_reg;

endmodule

// File: tb/tb_srec_load_ctrl.sv
// tb_srec_load_ctrl
//   Directed stimulus for srec_load_ctrl. Expected memory writes are queued
//   when stimulus is issued; a monitor pops and compares on every accepted
//   write (mem_req && mem_ack), one line per transaction. Status outputs
//   are checked directly at chosen points.
module tb_srec_load_ctrl;

    localparam int DEPTH = 4;
    localparam int HOLD  = 16;

`ifdef SREC_LOAD_CTRL_BOOT_HOLD_EN
    localparam logic IDLE_CPU = 1'b0;
`else
    localparam logic IDLE_CPU = 1'b1;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_progress;
    logic        format_error;
    logic        checksum_error;
    logic [31:0] write_address;
    logic [7:0]  write_byte;
    logic        write_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_req;
    logic        mem_ack;
    logic        cpu_reset_n;
    logic        load_done;
    logic        load_error;
    logic [15:0] word_count;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_ack_cyc = 0;

    srec_load_ctrl #(
        .FIFO_DEPTH        (DEPTH),
        .RESET_HOLD_CYCLES (HOLD)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_progress    (in_progress),
        .format_error   (format_error),
        .checksum_error (checksum_error),
        .write_address  (write_address),
        .write_byte     (write_byte),
        .write_enable   (write_enable),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .cpu_reset_n    (cpu_reset_n),
        .load_done      (load_done),
        .load_error     (load_error),
        .word_count     (word_count)
    );

    always #5 clock = ~clock;

    initial begin
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && mem_req === 1'b1 && mem_ack === 1'b1) begin
                checks = checks + 1;
                last_ack_cyc = cyc;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_write: got addr=%h data=%h be=%h, required no write",
                             mem_addr, mem_wdata, mem_be);
                end else begin
                    e = exp_q.pop_front();
                    $display("WRITE addr=%h data=%h be=%h (expected addr=%h data=%h be=%h)",
                             mem_addr, mem_wdata, mem_be, e.addr, e.data, e.be);
                    if (mem_addr !== e.addr || mem_wdata !== e.data || mem_be !== e.be) begin
                        errors = errors + 1;
                        $display("FAIL write_compare: got addr=%h data=%h be=%h, required addr=%h data=%h be=%h",
                                 mem_addr, mem_wdata, mem_be, e.addr, e.data, e.be);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.be   = be;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [31:0] a, input logic [7:0] d);
        write_address = a;
        write_byte    = d;
        write_enable  = 1'b1;
        tick();
        write_enable  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            send_byte(a + 32'(i), d[8*i +: 8]);
        end
    endtask

    task automatic wait_done(input string name, input int bound);
        int n;
        n = 0;
        while (!(load_done === 1'b1 && cpu_reset_n === 1'b1) && n < bound) begin
            tick();
            n++;
        end
        chk(name, 32'(load_done & cpu_reset_n), 32'd1);
    endtask

    initial begin
        logic [31:0] w;
        reset_n        = 1'b1;
        in_progress    = 1'b0;
        format_error   = 1'b0;
        checksum_error = 1'b0;
        write_address  = '0;
        write_byte     = '0;
        write_enable   = 1'b0;
        mem_ack        = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_mem_req",     32'(mem_req), 32'd0);
        chk("rst_mem_addr",    mem_addr, 32'd0);
        chk("rst_mem_wdata",   mem_wdata, 32'd0);
        chk("rst_mem_be",      32'(mem_be), 32'd0);
        chk("rst_word_count",  32'(word_count), 32'd0);
        chk("rst_load_done",   32'(load_done), 32'd0);
        chk("rst_load_error",  32'(load_error), 32'd0);
        chk("rst_cpu_reset_n", 32'(cpu_reset_n), 32'(IDLE_CPU));
        reset_n = 1'b1;
        tick();
        chk("idle_cpu_reset_n", 32'(cpu_reset_n), 32'(IDLE_CPU));

        // Full word, ack tied high
        mem_ack = 1'b1;
        in_progress = 1'b1;
        tick();
        chk("load_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        expect_write(32'h100, 32'h44332211, 4'hF);
        send_byte(32'h100, 8'h11);
        send_byte(32'h101, 8'h22);
        send_byte(32'h102, 8'h33);
        send_byte(32'h103, 8'h44);
        chk("req_latency_n1", 32'(mem_req), 32'd1);
        tick();
        chk("t1_word_count", 32'(word_count), 32'd1);
        chk("t1_req_drop", 32'(mem_req), 32'd0);
        in_progress = 1'b0;
        wait_done("t1_done", 40);

        // Partial words, flush, hold timing
        in_progress = 1'b1;
        tick();
        chk("t2_load_done_clr", 32'(load_done), 32'd0);
        chk("t2_word_count_clr", 32'(word_count), 32'd0);
        chk("t2_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        expect_write(32'h100, 32'h00AB0000, 4'h4);
        expect_write(32'h200, 32'h000000CD, 4'h1);
        send_byte(32'h102, 8'hAB);
        send_byte(32'h200, 8'hCD);
        in_progress = 1'b0;
        wait_done("t2_done", 40);
        chk("t2_hold_latency", 32'(cyc - last_ack_cyc), 32'(HOLD + 1));
        chk("t2_word_count", 32'(word_count), 32'd2);

        // Lane overwrite, out-of-order bytes, back-to-back drain
        mem_ack = 1'b0;
        in_progress = 1'b1;
        tick();
        expect_write(32'h300, 32'h04030209, 4'hF);
        expect_write(32'h304, 32'h88776655, 4'hF);
        send_byte(32'h300, 8'h01);
        send_byte(32'h300, 8'h09);
        send_byte(32'h301, 8'h02);
        send_byte(32'h302, 8'h03);
        send_byte(32'h303, 8'h04);
        send_byte(32'h307, 8'h88);
        send_byte(32'h306, 8'h77);
        send_byte(32'h305, 8'h66);
        send_byte(32'h304, 8'h55);
        chk("t3_held_addr", mem_addr, 32'h300);
        mem_ack = 1'b1;
        tick();
        chk("t3_b2b_req", 32'(mem_req), 32'd1);
        chk("t3_b2b_addr", mem_addr, 32'h304);
        tick();
        chk("t3_req_drop", 32'(mem_req), 32'd0);
        in_progress = 1'b0;
        wait_done("t3_done", 40);
        chk("t3_word_count", 32'(word_count), 32'd2);

        // Address wrap
        in_progress = 1'b1;
        tick();
        expect_write(32'hFFFFFFFC, 32'h5A000000, 4'h8);
        expect_write(32'h00000000, 32'h000000A5, 4'h1);
        send_byte(32'hFFFFFFFF, 8'h5A);
        send_byte(32'h00000000, 8'hA5);
        in_progress = 1'b0;
        wait_done("t4_done", 40);
        chk("t4_word_count", 32'(word_count), 32'd2);

        // FIFO overflow
        mem_ack = 1'b0;
        in_progress = 1'b1;
        tick();
        expect_write(32'h400, 32'h03020100, 4'hF);
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                w[8*j +: 8] = 8'(k * 4 + j);
            end
            send_word(32'h400 + 32'(4 * k), w);
        end
        chk("ovf_load_error", 32'(load_error), 32'd1);
        chk("ovf_req_held", 32'(mem_req), 32'd1);
        chk("ovf_addr_held", mem_addr, 32'h400);
        chk("ovf_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        mem_ack = 1'b1;
        repeat (6) tick();
        chk("ovf_req_dead", 32'(mem_req), 32'd0);
        chk("ovf_error_sticky", 32'(load_error), 32'd1);

        // Reset clears the error
        in_progress = 1'b0;
        mem_ack = 1'b0;
        reset_n = 1'b0;
        tick();
        chk("rst2_load_error", 32'(load_error), 32'd0);
        reset_n = 1'b1;
        tick();

        // Checksum error with a request outstanding
        in_progress = 1'b1;
        tick();
        expect_write(32'h500, 32'hA3A2A1A0, 4'hF);
        send_word(32'h500, 32'hA3A2A1A0);
        send_byte(32'h504, 8'hEE);
        checksum_error = 1'b1;
        tick();
        chk("cks_load_error", 32'(load_error), 32'd1);
        chk("cks_req_held", 32'(mem_req), 32'd1);
        chk("cks_addr_held", mem_addr, 32'h500);
        chk("cks_data_held", mem_wdata, 32'hA3A2A1A0);
        chk("cks_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        send_word(32'h508, 32'hDEADBEEF);
        mem_ack = 1'b1;
        repeat (6) tick();
        chk("cks_req_dead", 32'(mem_req), 32'd0);
        checksum_error = 1'b0;

        // Asynchronous reset during a request
        mem_ack = 1'b0;
        in_progress = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        in_progress = 1'b1;
        tick();
        send_word(32'h600, 32'h12345678);
        chk("ar_req_before", 32'(mem_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_mem_req", 32'(mem_req), 32'd0);
        chk("ar_mem_addr", mem_addr, 32'd0);
        chk("ar_mem_wdata", mem_wdata, 32'd0);
        chk("ar_mem_be", 32'(mem_be), 32'd0);
        chk("ar_word_count", 32'(word_count), 32'd0);
        chk("ar_load_done", 32'(load_done), 32'd0);
        chk("ar_load_error", 32'(load_error), 32'd0);
        chk("ar_cpu_reset_n", 32'(cpu_reset_n), 32'(IDLE_CPU));
        in_progress = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        chk("ar_idle_req", 32'(mem_req), 32'd0);
        chk("ar_idle_cpu_reset_n", 32'(cpu_reset_n), 32'(IDLE_CPU));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
